// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32 MEM stage: word load/store bus FSM, pipeline stall, MEM/WB registers, bus watchdog
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PIP_write_mem_i,
    input  logic        PIP_read_mem_i,
    input  logic [31:0] PIP_alu_result_i,
    input  logic [31:0] PIP_second_operand_i,
    input  logic        PIP_use_mem_i,
    input  logic        PIP_write_reg_i,
    input  logic [4:0]  PIP_rd_i,
    output logic        stall_o,
    output logic        dmem_valid_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        PIP_write_reg_o,
    output logic [4:0]  PIP_rd_o,
    output logic [31:0] PIP_wb_data_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_reg_q;
    logic [4:0]       rd_q;
    logic [31:0]      wb_data_q;
    logic             bus_err_q;

    logic mem_op, is_store, stall, valid, load_done, complete, expire, timeout;
    logic unused_use_mem;

    // Write-back source is chosen by FSM completion, so the use_mem hint is not needed.
    assign unused_use_mem = PIP_use_mem_i;
    assign mem_op   = PIP_read_mem_i | PIP_write_mem_i;
    assign is_store = PIP_write_mem_i;
    assign timeout  = (TIMEOUT_CYCLES != 0) && (state_q != IDLE)
                   && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        valid     = 1'b0;
        load_done = 1'b0;
        complete  = 1'b0;
        expire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    valid = 1'b1;
                    if (dmem_ready_i) begin
                        if (!is_store) begin
                            stall   = 1'b1;
                            state_d = WAIT_RESP;
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                valid = 1'b1;
                if (dmem_ready_i) begin
                    if (is_store) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT_RESP;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (dmem_rvalid_i) begin
                    load_done = 1'b1;
                    complete  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completion on the expiry cycle takes priority over abandoning the access.
        if (timeout && !complete) begin
            stall   = 1'b0;
            valid   = 1'b0;
            expire  = 1'b1;
            state_d = IDLE;
        end

        // The counter includes the issuing IDLE cycle, so it counts cycles since the request.
        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (state_q == IDLE) begin
            cnt_d = CNT_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_reg_q <= 1'b0;
            rd_q        <= 5'd0;
            wb_data_q   <= 32'd0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= expire;
            if (stall || expire) begin
                write_reg_q <= 1'b0;
                rd_q        <= 5'd0;
                wb_data_q   <= 32'd0;
            end else begin
                write_reg_q <= PIP_write_reg_i;
                rd_q        <= PIP_rd_i;
                wb_data_q   <= load_done ? dmem_rdata_i : PIP_alu_result_i;
            end
        end
    end

    assign stall_o         = stall & ~reset;
    assign dmem_valid_o    = valid & ~reset;
    assign dmem_we_o       = valid & is_store & ~reset;
    assign dmem_addr_o     = {PIP_alu_result_i[31:2], 2'b00};
    assign dmem_wdata_o    = PIP_second_operand_i;
    assign PIP_write_reg_o = write_reg_q;
    assign PIP_rd_o        = rd_q;
    assign PIP_wb_data_o   = wb_data_q;
    assign bus_err_o       = bus_err_q;

endmodule
